// File: rtl/xor_mismatch_monitor.sv
// Registered bitwise compare of two words with per-bit mask, saturating mismatch
// counter and sticky alarm FSM. Optional first-mismatch capture: MISMATCH_CAPTURE_EN.
//
// state | meaning
// IDLE  | no mismatch run in progress
// RUN   | 1..THRESH-1 consecutive valid mismatches seen
// ALARM | THRESH consecutive mismatches reached; sticky until clr/reset
module xor_mismatch_monitor #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 16,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  input  logic             clr,
  output logic             out_valid,
  output logic             match,
  output logic [WIDTH-1:0] mismatch_bits,
  output logic [CNT_W-1:0] err_cnt,
  output logic             alarm,
  output logic [1:0]       state,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_a,
  output logic [WIDTH-1:0] cap_b
);

  localparam int RUN_W = $clog2(THRESH + 1);
  localparam logic [RUN_W-1:0] THRESH_R = RUN_W'(THRESH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;

  logic [WIDTH-1:0] mbits_c;
  logic             mis_c;

  logic             out_valid_d, out_valid_q;
  logic             match_d, match_q;
  logic [WIDTH-1:0] mbits_d, mbits_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic [RUN_W-1:0] run_d, run_q;
  logic [1:0]       state_d, state_q;
  logic             alarm_d, alarm_q;

  assign mbits_c = (a ^ b) & ~mask;
  assign mis_c   = |mbits_c;

  always_comb begin
    out_valid_d = 1'b0;
    match_d     = match_q;
    mbits_d     = mbits_q;
    err_cnt_d   = err_cnt_q;
    run_d       = run_q;
    state_d     = state_q;
    if (clr) begin
      // a sample arriving with clr is discarded entirely
      err_cnt_d = '0;
      run_d     = '0;
      state_d   = ST_IDLE;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      match_d     = ~mis_c;
      mbits_d     = mbits_c;
      if (mis_c && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (mis_c) begin
            run_d   = RUN_W'(1);
            state_d = (THRESH_R == RUN_W'(1)) ? ST_ALARM : ST_RUN;
          end
        end
        ST_RUN: begin
          if (mis_c) begin
            run_d = run_q + 1'b1;
            if (run_q + 1'b1 == THRESH_R) begin
              state_d = ST_ALARM;
            end
          end else begin
            run_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_ALARM: state_d = ST_ALARM;
        default: begin
          run_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
    alarm_d = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      match_q     <= 1'b1;
      mbits_q     <= '0;
      err_cnt_q   <= '0;
      run_q       <= '0;
      state_q     <= ST_IDLE;
      alarm_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      match_q     <= match_d;
      mbits_q     <= mbits_d;
      err_cnt_q   <= err_cnt_d;
      run_q       <= run_d;
      state_q     <= state_d;
      alarm_q     <= alarm_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign match         = match_q;
  assign mismatch_bits = mbits_q;
  assign err_cnt       = err_cnt_q;
  assign alarm         = alarm_q;
  assign state         = state_q;

`ifdef MISMATCH_CAPTURE_EN
  logic             cap_valid_d, cap_valid_q;
  logic [WIDTH-1:0] cap_a_d, cap_a_q;
  logic [WIDTH-1:0] cap_b_d, cap_b_q;

  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_a_d     = cap_a_q;
    cap_b_d     = cap_b_q;
    if (clr) begin
      cap_valid_d = 1'b0;
      cap_a_d     = '0;
      cap_b_d     = '0;
    end else if (in_valid && mis_c && !cap_valid_q) begin
      cap_valid_d = 1'b1;
      cap_a_d     = a;
      cap_b_d     = b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid_q <= 1'b0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
    end
  end

  assign cap_valid = cap_valid_q;
  assign cap_a     = cap_a_q;
  assign cap_b     = cap_b_q;
`else
  assign cap_valid = 1'b0;
  assign cap_a     = '0;
  assign cap_b     = '0;
`endif

endmodule

// File: tb/tb_xor_mismatch_monitor.sv
// Directed + random bench for xor_mismatch_monitor; a scoreboard queue holds the
// expected compare result of each accepted sample, a small model tracks counter/FSM.
module tb_xor_mismatch_monitor;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, clr;
  logic [7:0] a, b, mask;

  logic        out_valid, match, alarm, cap_valid;
  logic [7:0]  mismatch_bits, cap_a, cap_b;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  logic        s_out_valid, s_match, s_alarm, s_cap_valid;
  logic [7:0]  s_mismatch_bits, s_cap_a, s_cap_b;
  logic [2:0]  s_err_cnt;
  logic [1:0]  s_state;

  always #5 clk = ~clk;

  xor_mismatch_monitor #(.WIDTH(8), .CNT_W(16), .THRESH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .mask(mask),
    .clr(clr), .out_valid(out_valid), .match(match), .mismatch_bits(mismatch_bits),
    .err_cnt(err_cnt), .alarm(alarm), .state(state), .cap_valid(cap_valid),
    .cap_a(cap_a), .cap_b(cap_b)
  );

  // narrow counter copy so saturation is reached in a few samples
  xor_mismatch_monitor #(.WIDTH(8), .CNT_W(3), .THRESH(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .mask(mask),
    .clr(clr), .out_valid(s_out_valid), .match(s_match),
    .mismatch_bits(s_mismatch_bits), .err_cnt(s_err_cnt), .alarm(s_alarm),
    .state(s_state), .cap_valid(s_cap_valid), .cap_a(s_cap_a), .cap_b(s_cap_b)
  );

  typedef struct packed {
    logic       match;
    logic [7:0] mb;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic        m_ov, m_match, m_cv;
  logic [7:0]  m_mb, m_ca, m_cb;
  int          m_err, m_run;
  logic [1:0]  m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_match = 1'b1; m_mb = '0; m_err = 0; m_run = 0; m_st = 2'd0;
    m_cv = 1'b0; m_ca = '0; m_cb = '0;
    sb_q.delete();
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] ia,
                      input logic [7:0] ib, input logic [7:0] im, input logic c);
    logic [7:0] mb;
    logic       mis;
    exp_t       e;
    @(negedge clk);
    rst_n = r; in_valid = v; a = ia; b = ib; mask = im; clr = c;
    mb  = (ia ^ ib) & ~im;
    mis = |mb;
    if (!r) begin
      model_reset();
    end else if (c) begin
      m_ov = 1'b0; m_err = 0; m_run = 0; m_st = 2'd0;
      m_cv = 1'b0; m_ca = '0; m_cb = '0;
    end else if (v) begin
      m_ov = 1'b1;
      sb_q.push_back('{match: ~mis, mb: mb});
      if (mis) begin
        if (m_err < 65535) m_err++;
`ifdef MISMATCH_CAPTURE_EN
        if (!m_cv) begin m_cv = 1'b1; m_ca = ia; m_cb = ib; end
`endif
      end
      if (m_st == 2'd0 && mis) begin
        m_run = 1; m_st = 2'd1;
      end else if (m_st == 2'd1) begin
        if (mis) begin
          m_run++;
          if (m_run == 4) m_st = 2'd2;
        end else begin
          m_run = 0; m_st = 2'd0;
        end
      end
    end else begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        m_match = e.match;
        m_mb    = e.mb;
      end
    end
    chk("match", 32'(match), 32'(m_match));
    chk("mismatch_bits", 32'(mismatch_bits), 32'(m_mb));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    chk("state", 32'(state), 32'(m_st));
    chk("alarm", 32'(alarm), 32'(m_st == 2'd2));
    chk("cap_valid", 32'(cap_valid), 32'(m_cv));
    chk("cap_a", 32'(cap_a), 32'(m_ca));
    chk("cap_b", 32'(cap_b), 32'(m_cb));
    chk("sat_err_cnt", 32'(s_err_cnt), 32'((m_err > 7) ? 7 : m_err));
    chk("sat_state", 32'(s_state), 32'(m_st));
    chk("sat_alarm", 32'(s_alarm), 32'(m_st == 2'd2));
    chk("sat_out", {22'd0, s_out_valid, s_match, s_mismatch_bits}, {22'd0, m_ov, m_match, m_mb});
    chk("sat_cap", {15'd0, s_cap_valid, s_cap_a, s_cap_b}, {15'd0, m_cv, m_ca, m_cb});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; a = '0; b = '0; mask = '0;
    model_reset();
    step(0, 1, 8'h00, 8'hFF, 8'h00, 0);
    chk("reset_match_const", 32'(match), 32'd1);
    chk("reset_err_const", 32'(err_cnt), 32'd0);
    step(1, 0, 8'h00, 8'h00, 8'h00, 0);

    step(1, 1, 8'h5A, 8'h5A, 8'h00, 0);
    chk("eq_match", 32'(match), 32'd1);
    step(1, 1, 8'hF0, 8'hF1, 8'h01, 0);
    chk("masked_mb", 32'(mismatch_bits), 32'd0);
    step(1, 1, 8'hF0, 8'hF1, 8'h00, 0);
    chk("unmasked_mb", 32'(mismatch_bits), 32'h01);
    chk("first_err", 32'(err_cnt), 32'd1);
    chk("first_run", 32'(state), 32'd1);

    step(1, 0, 8'h00, 8'h00, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 8'h00, 8'hFF, 8'h00, 0);
    chk("alarm_after_4", 32'(alarm), 32'd1);
    chk("alarm_err", 32'(err_cnt), 32'd4);
    step(1, 0, 8'h11, 8'h22, 8'h00, 0);
    step(1, 1, 8'h33, 8'h33, 8'h00, 0);
    chk("alarm_sticky", 32'(state), 32'd2);
    step(1, 1, 8'h00, 8'hFF, 8'h00, 1);
    chk("clr_err", 32'(err_cnt), 32'd0);
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_ov", 32'(out_valid), 32'd0);

    for (int i = 0; i < 3; i++) step(1, 1, 8'h00, 8'hFF, 8'h00, 0);
    step(1, 1, 8'h77, 8'h77, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'h00, 8'hFF, 8'h00, 0);
    chk("no_alarm_err", 32'(err_cnt), 32'd6);
    chk("no_alarm_state", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 1, 8'h0F, 8'hF0, 8'h00, 0);
    chk("sat_hold", 32'(s_err_cnt), 32'd7);

    step(1, 0, 8'h00, 8'h00, 8'h00, 1);
    step(1, 1, 8'h12, 8'h13, 8'h00, 0);
    step(1, 1, 8'hAA, 8'h55, 8'h00, 0);
`ifdef MISMATCH_CAPTURE_EN
    chk("cap_a_first", 32'(cap_a), 32'h12);
    chk("cap_b_first", 32'(cap_b), 32'h13);
`else
    chk("cap_a_off", 32'(cap_a), 32'h0);
`endif
    step(1, 0, 8'h00, 8'h00, 8'h00, 1);

    step(1, 1, 8'h01, 8'h02, 8'h00, 0);
    step(1, 1, 8'h01, 8'h02, 8'h00, 0);
    step(0, 1, 8'h01, 8'h02, 8'h00, 0);
    chk("rst_mid_run_state", 32'(state), 32'd0);
    chk("rst_mid_run_match", 32'(match), 32'd1);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] ra, rb, rm;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : 8'($urandom);
      rm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(1, 1'($urandom_range(0, 3) != 0), ra, rb, rm, ($urandom_range(0, 15) == 0));
    end

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xor_mismatch_monitor.md
Name: xor_mismatch_monitor

Overview:
- Parametrised, clocked successor to the team's 3-input gate-level match function (p = 0 only when c = 0 and a differs from b).
- Compares two WIDTH-bit words bit-by-bit, with a per-bit override mask in the role of c, and registers the word-level match result.
- Counts mismatches and raises a sticky alarm after THRESH consecutive mismatching samples.
- Sits in datapath self-check / lockstep-compare logic.

Parameters:
- WIDTH, 8, bit width of compared words (>=1)
- CNT_W, 16, width of saturating total-mismatch counter
- THRESH, 4, consecutive valid mismatches needed to enter ALARM (>=1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset; synchronous and active-low
- in_valid  in  1  a, b, mask sampled this cycle
- a  in  WIDTH  operand word A
- b  in  WIDTH  operand word B
- mask  in  WIDTH  per-bit override; mask[i]=1 forces bit i to match
- clr  in  1  synchronous clear of counters, alarm and FSM
- out_valid  out  1  registered pulse; match/mismatch_bits refer to the sample taken last cycle
- match  out  1  registered word match (1 = all bits match or are masked)
- mismatch_bits  out  WIDTH  registered (a ^ b) & ~mask
- err_cnt  out  CNT_W  total valid mismatches, saturating
- alarm  out  1  sticky; high while FSM is in ALARM
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 ALARM

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, match=1, mismatch_bits=0, err_cnt=0, alarm=0, state=IDLE, internal run counter=0.
  - Reset mid-run or mid-ALARM returns everything to these values on the same edge.
- Per-bit function: m[i] = ~(a[i]^b[i]) | mask[i]. Word match = AND of all m[i]. Bit i is a mismatch iff a[i]!=b[i] and mask[i]=0.
- Latency: sample at edge N when in_valid=1. out_valid=1 with match and mismatch_bits at N+1. Counter and FSM effects are visible at N+1.
- When in_valid=0: out_valid=0; match and mismatch_bits hold their last value; counter, run counter and FSM are unchanged.
- err_cnt: increments by 1 on each valid mismatch and saturates at 2^CNT_W-1 (no wrap).
- Run counter: width clog2(THRESH+1).
- FSM transitions, evaluated only on valid samples:
  - IDLE: mismatch -> RUN with run=1, or -> ALARM directly if THRESH==1. Match -> stay in IDLE.
  - RUN: mismatch -> run+1; when run+1==THRESH -> ALARM. Match -> IDLE, run=0.
  - ALARM: absorbing; only clr or reset leave it. Matches do not clear it. err_cnt keeps counting.
- clr (rst_n=1): next edge sets err_cnt=0, run=0, state=IDLE, alarm=0, out_valid=0.
  - clr has priority over a simultaneous in_valid: that sample is discarded entirely (not counted, match/mismatch_bits hold).
- alarm == (state==ALARM), registered; no combinational paths from inputs to outputs.

Optional Feature:
- Macro MISMATCH_CAPTURE_EN adds outputs cap_valid (1), cap_a (WIDTH), cap_b (WIDTH). The ports are always present.
- Defined:
  - On the first valid mismatch after reset or clr, latch a and b into cap_a/cap_b and set cap_valid=1 at the next edge.
  - Later mismatches do not overwrite the capture.
  - clr or reset clears all three to 0.
- Undefined: cap_valid, cap_a, cap_b are tied to 0 and no capture registers are built.

Test Plan (WIDTH=8, THRESH=4, CNT_W=16):
- Reset, then a=8'h5A, b=8'h5A, mask=0, in_valid=1 -> next cycle out_valid=1, match=1, mismatch_bits=0, err_cnt=0, state=IDLE.
- a=8'hF0, b=8'hF1, mask=8'h01 -> match=1, mismatch_bits=0 (masked). Same data with mask=0 -> match=0, mismatch_bits=8'h01, err_cnt=1, state=RUN.
- Four consecutive valid mismatches (a=8'h00, b=8'hFF) -> alarm=1, state=ALARM one cycle after the 4th sample, err_cnt=4. Three mismatches, one match, then three mismatches -> never ALARM, err_cnt=6.
- In ALARM, apply clr together with in_valid=1 and a mismatch -> next cycle err_cnt=0, state=IDLE, alarm=0, out_valid=0, sample not counted.
- Force err_cnt to 16'hFFFE (CNT_W=16), then 3 mismatches -> err_cnt stays 16'hFFFF. Deassert rst_n mid-RUN with in_valid=1 -> all outputs at reset values next edge.
- With MISMATCH_CAPTURE_EN: mismatches (8'h12 vs 8'h13), then (8'hAA vs 8'h55) -> cap_a=8'h12, cap_b=8'h13, cap_valid=1. clr -> all zero. Without the macro -> cap_* are always 0.
